key_tone_gen: RTL and testbench

//  Downstream of the 8-key debouncer: consumes the debounced key vector, picks one key by

---
 rtl/organ_pkg.sv | 23 ++
 rtl/tone_divider.sv | 35 +++
 rtl/key_tone_gen.sv | 136 +++++++++++++
 tb/tb_key_tone_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/organ_pkg.sv
// Shared definitions for the key organ: note table, half-period helper and FSM encodings.
package organ_pkg;

    localparam int NUM_KEYS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // C4..C5 in hundredths of a hertz, so the table stays integer
    localparam int unsigned NOTE_HZ_X100 [NUM_KEYS] = '{
        26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325
    };

    function automatic logic [63:0] half_period(input logic [63:0] clk_hz, input logic [2:0] idx);
        logic [63:0] num;
        num = clk_hz * 64'd50;
        return num / 64'(NOTE_HZ_X100[idx]);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter with a toggle flop; clr restarts the wave low with a fresh count.
module tone_divider #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] half,
    output logic             tone
);

    logic [CNT_W-1:0] cnt_reg;
    logic             tone_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            tone_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            tone_reg <= 1'b0;
        end else if (en) begin
            if (cnt_reg == half - CNT_W'(1)) begin
                cnt_reg  <= '0;
                tone_reg <= ~tone_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign tone = tone_reg;

endmodule

// File: rtl/key_tone_gen.sv
// Picks the lowest pressed key, plays its note as a square wave and holds it for a release tail.
module key_tone_gen
    import organ_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned RELEASE_CYC = 5_000_000,
    parameter int          CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_p,
    input  logic       mute,
    output logic       tone_o,
    output logic [2:0] note_idx,
    output logic       note_on,
    output logic       playing
);

    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [REL_W-1:0] REL_LAST = (RELEASE_CYC > 0) ? REL_W'(RELEASE_CYC - 1) : '0;

    state_t           state_reg, state_next;
    logic [7:0]       key_reg;
    logic             mute_reg;
    logic [2:0]       cur_reg, cur_next;
    logic [REL_W-1:0] rel_reg, rel_next;
    logic             note_on_reg, note_on_next;
    logic             clr;
    logic             tone_q;
    logic             any;
    logic [2:0]       sel;
    logic [CNT_W-1:0] half_tab [NUM_KEYS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_half
            assign half_tab[gi] = CNT_W'(half_period(64'(CLK_HZ), 3'(gi)));
        end
    endgenerate

    assign any = |key_reg;

    // Scan high to low so the lowest set bit is the last assignment to stick
    always_comb begin
        sel = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_reg[i]) sel = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            key_reg     <= '0;
            mute_reg    <= 1'b0;
            cur_reg     <= '0;
            rel_reg     <= '0;
            note_on_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            key_reg     <= key_p;
            mute_reg    <= mute;
            cur_reg     <= cur_next;
            rel_reg     <= rel_next;
            note_on_reg <= note_on_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_next     = cur_reg;
        rel_next     = rel_reg;
        note_on_next = 1'b0;
        clr          = 1'b0;
        case (state_reg)
            IDLE: begin
                clr = 1'b1;
                if (any) begin
                    state_next   = PLAY;
                    cur_next     = sel;
                    note_on_next = 1'b1;
                end
            end
            PLAY: begin
                if (any) begin
                    if (sel != cur_reg) begin
                        cur_next     = sel;
                        note_on_next = 1'b1;
                        clr          = 1'b1;
                    end
                end else if (RELEASE_CYC == 0) begin
                    state_next = IDLE;
                    clr        = 1'b1;
                end else begin
                    state_next = RELEASE;
                    rel_next   = '0;
                end
            end
            RELEASE: begin
                if (any) begin
                    // A press during the tail always retriggers, even on the same key
                    state_next   = PLAY;
                    cur_next     = sel;
                    note_on_next = 1'b1;
                    clr          = 1'b1;
                end else if (rel_reg == REL_LAST) begin
                    state_next = IDLE;
                    clr        = 1'b1;
                end else begin
                    rel_next = rel_reg + REL_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                clr        = 1'b1;
            end
        endcase
    end

    tone_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_reg != IDLE),
        .clr  (clr),
        .half (half_tab[cur_reg]),
        .tone (tone_q)
    );

    assign tone_o   = tone_q & ~mute_reg;
    assign note_idx = cur_reg;
    assign note_on  = note_on_reg;
    assign playing  = (state_reg != IDLE);

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen: one instance with a 100-cycle tail, one with no tail.
module tb_key_tone_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_p;
    logic       mute;
    logic       tone_o, note_on, playing;
    logic [2:0] note_idx;
    logic       z_tone_o, z_note_on, z_playing;
    logic [2:0] z_note_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_tone_gen #(.CLK_HZ(1_000_000), .RELEASE_CYC(100), .CNT_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .key_p(key_p), .mute(mute),
        .tone_o(tone_o), .note_idx(note_idx), .note_on(note_on), .playing(playing)
    );

    key_tone_gen #(.CLK_HZ(1_000_000), .RELEASE_CYC(0), .CNT_W(17)) dut0 (
        .clk(clk), .rst_n(rst_n), .key_p(key_p), .mute(mute),
        .tone_o(z_tone_o), .note_idx(z_note_idx), .note_on(z_note_on), .playing(z_playing)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Negedges until tone_o changes; -1 if it never does within the budget
    task automatic measure_toggle(output int n);
        logic prev;
        prev = tone_o;
        n = -1;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            if (tone_o !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_rise(output int ok);
        int n;
        ok = 0;
        for (int k = 0; k < 3; k++) begin
            measure_toggle(n);
            if (n < 0) break;
            if (tone_o === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mute  = 1'b0;
        key_p = 8'h00;
        for (int i = 0; i < 10; i++) begin
            key_p = 8'($urandom);
            tick(1);
            checks++;
            if ({tone_o, playing, note_idx, note_on} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b expected 000000", i, {tone_o, playing, note_idx, note_on});
            end
        end
        key_p = 8'h00;
        rst_n = 1'b1;
        tick(3);
        checks++;
        if ({tone_o, playing, note_idx, note_on} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000000", {tone_o, playing, note_idx, note_on});
        end
        $display("test_reset done");
    endtask

    task automatic test_press;
        int n;
        key_p = 8'h20;
        tick(1);
        checks++;
        if (note_on !== 1'b0) begin errors++; $display("FAIL press_note_on_early: got %0b expected 0", note_on); end
        tick(1);
        checks++;
        if ({note_on, playing, note_idx, tone_o} !== {1'b1, 1'b1, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL press_start: got on=%0b play=%0b idx=%0d tone=%0b expected on=1 play=1 idx=5 tone=0",
                     note_on, playing, note_idx, tone_o);
        end
        tick(1);
        checks++;
        if (note_on !== 1'b0) begin errors++; $display("FAIL press_pulse_width: got %0b expected 0", note_on); end
        measure_toggle(n);
        checks++;
        if (n != 1135) begin errors++; $display("FAIL press_first_edge: got %0d expected 1135", n); end
        measure_toggle(n);
        checks++;
        if (n != 1136) begin errors++; $display("FAIL press_half_period: got %0d expected 1136", n); end
        $display("test_press done");
    endtask

    task automatic test_note_change;
        int n;
        key_p = 8'h21;
        tick(1);
        checks++;
        if (playing !== 1'b1) begin errors++; $display("FAIL change_playing: got %0b expected 1", playing); end
        tick(1);
        checks++;
        if ({note_on, note_idx, tone_o} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL change_to_c4: got on=%0b idx=%0d tone=%0b expected on=1 idx=0 tone=0", note_on, note_idx, tone_o);
        end
        measure_toggle(n);
        checks++;
        if (n != 1911) begin errors++; $display("FAIL c4_first_edge: got %0d expected 1911", n); end
        measure_toggle(n);
        checks++;
        if (n != 1911) begin errors++; $display("FAIL c4_half_period: got %0d expected 1911", n); end
        key_p = 8'h20;
        tick(2);
        checks++;
        if ({note_on, playing, note_idx} !== {1'b1, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL change_back: got on=%0b play=%0b idx=%0d expected on=1 play=1 idx=5", note_on, playing, note_idx);
        end
        measure_toggle(n);
        checks++;
        if (n != 1136) begin errors++; $display("FAIL back_first_edge: got %0d expected 1136", n); end
        $display("test_note_change done");
    endtask

    task automatic test_release;
        int n, ok;
        wait_rise(ok);
        checks++;
        if (ok != 1) begin errors++; $display("FAIL release_wait_rise: got %0d expected 1", ok); end
        key_p = 8'h00;
        tick(101);
        checks++;
        if ({playing, tone_o} !== 2'b11) begin
            errors++;
            $display("FAIL release_tail: got play=%0b tone=%0b expected play=1 tone=1", playing, tone_o);
        end
        tick(1);
        checks++;
        if ({playing, tone_o, note_idx, note_on} !== {1'b0, 1'b0, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL release_end: got play=%0b tone=%0b idx=%0d on=%0b expected play=0 tone=0 idx=5 on=0",
                     playing, tone_o, note_idx, note_on);
        end
        key_p = 8'h20;
        tick(2);
        checks++;
        if (note_on !== 1'b1) begin errors++; $display("FAIL repress_note_on: got %0b expected 1", note_on); end
        tick(10);
        key_p = 8'h00;
        tick(51);
        checks++;
        if (playing !== 1'b1) begin errors++; $display("FAIL retrigger_in_tail: got %0b expected 1", playing); end
        key_p = 8'h20;
        tick(2);
        checks++;
        if ({note_on, playing, note_idx, tone_o} !== {1'b1, 1'b1, 3'd5, 1'b0}) begin
            errors++;
            $display("FAIL retrigger: got on=%0b play=%0b idx=%0d tone=%0b expected on=1 play=1 idx=5 tone=0",
                     note_on, playing, note_idx, tone_o);
        end
        measure_toggle(n);
        checks++;
        if (n != 1136) begin errors++; $display("FAIL retrigger_phase: got %0d expected 1136", n); end
        $display("test_release done");
    endtask

    task automatic test_mute;
        int n, ok;
        wait_rise(ok);
        checks++;
        if (ok != 1) begin errors++; $display("FAIL mute_wait_rise: got %0d expected 1", ok); end
        mute = 1'b1;
        tick(2);
        checks++;
        if ({tone_o, playing, note_idx} !== {1'b0, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL mute_on: got tone=%0b play=%0b idx=%0d expected tone=0 play=1 idx=5", tone_o, playing, note_idx);
        end
        tick(298);
        mute = 1'b0;
        tick(2);
        checks++;
        if (tone_o !== 1'b1) begin errors++; $display("FAIL mute_off_phase: got %0b expected 1", tone_o); end
        measure_toggle(n);
        checks++;
        if (n != 834) begin errors++; $display("FAIL mute_running_phase: got %0d expected 834", n); end
        $display("test_mute done");
    endtask

    task automatic test_reset_mid_note;
        int ok;
        wait_rise(ok);
        checks++;
        if (ok != 1) begin errors++; $display("FAIL rstmid_wait_rise: got %0d expected 1", ok); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tone_o, playing, note_idx, note_on, z_tone_o, z_playing} !== 8'b0) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected 00000000",
                     {tone_o, playing, note_idx, note_on, z_tone_o, z_playing});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (note_on !== 1'b0) begin errors++; $display("FAIL rstmid_on_early: got %0b expected 0", note_on); end
        tick(1);
        checks++;
        if ({note_on, playing, note_idx, z_note_on} !== {1'b1, 1'b1, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_restart: got on=%0b play=%0b idx=%0d z_on=%0b expected on=1 play=1 idx=5 z_on=1",
                     note_on, playing, note_idx, z_note_on);
        end
        $display("test_reset_mid_note done");
    endtask

    task automatic test_no_tail;
        int ok;
        wait_rise(ok);
        checks++;
        if ({ok[0], z_tone_o, z_note_idx} !== {1'b1, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL notail_before: got ok=%0d tone=%0b idx=%0d expected ok=1 tone=1 idx=5", ok, z_tone_o, z_note_idx);
        end
        key_p = 8'h00;
        tick(1);
        checks++;
        if (z_playing !== 1'b1) begin errors++; $display("FAIL notail_playing_early: got %0b expected 1", z_playing); end
        tick(1);
        checks++;
        if ({z_playing, z_tone_o, z_note_idx, playing} !== {1'b0, 1'b0, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL notail_idle: got play=%0b tone=%0b idx=%0d tailplay=%0b expected play=0 tone=0 idx=5 tailplay=1",
                     z_playing, z_tone_o, z_note_idx, playing);
        end
        $display("test_no_tail done");
    endtask

    initial begin
        test_reset();
        test_press();
        test_note_change();
        test_release();
        test_mute();
        test_reset_mid_note();
        test_no_tail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
